// File: rtl/pc_update.sv
// Fetch-stage program counter with redirect handling and a fixed-length flush window.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_CHECK_EN.
module pc_update #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
   parameter int                    INSTR_BYTES  = 4,
   parameter int                    FLUSH_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [1:0]            pc_src,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic                  stall,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc_next_seq,
   output logic                  fetch_valid,
   output logic                  flush,
   output logic                  redirect
`ifdef PC_MISALIGN_CHECK_EN
   ,
   output logic                  misalign_fault
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES);
`ifdef PC_MISALIGN_CHECK_EN
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
`endif

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    flush_q, flush_d;
   logic                    redirect_q, redirect_d;
`ifdef PC_MISALIGN_CHECK_EN
   logic                    misalign_q, misalign_d;
`endif

   logic                    is_jump;
   logic                    is_branch;
   logic [ADDR_WIDTH-1:0]   target;

   assign is_jump     = (pc_src == 2'b10);
   assign is_branch   = (pc_src == 2'b01);
   assign target      = is_jump ? jump_target : branch_target;
   assign pc_next_seq = pc_q + PC_STEP;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      flush_d    = flush_q;
      redirect_d = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         IDLE: state_d = RUN;
         RUN, FLUSH: begin
            if (is_jump || is_branch) begin
`ifdef PC_MISALIGN_CHECK_EN
               if ((target & ALIGN_MASK) != '0) begin
                  state_d    = HALT;
                  misalign_d = 1'b1;
                  flush_d    = 1'b1;
               end else begin
                  pc_d       = target;
                  redirect_d = 1'b1;
                  flush_d    = 1'b1;
                  cnt_d      = FLUSH_LOAD;
                  state_d    = FLUSH;
               end
`else
               pc_d       = target;
               redirect_d = 1'b1;
               flush_d    = 1'b1;
               cnt_d      = FLUSH_LOAD;
               state_d    = FLUSH;
`endif
            end else begin
               if (!stall) begin
                  pc_d = pc_next_seq;
               end
               // The flush window keeps counting down even while decode stalls.
               if (state_q == FLUSH) begin
                  if (cnt_q <= 4'd1) begin
                     cnt_d   = 4'd0;
                     flush_d = 1'b0;
                     state_d = RUN;
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
            end
         end
         default: begin
`ifdef PC_MISALIGN_CHECK_EN
            flush_d = 1'b1;
`else
            state_d = IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         cnt_q      <= 4'd0;
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
`ifdef PC_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign pc          = pc_q;
   assign flush       = flush_q;
   assign redirect    = redirect_q;
   assign fetch_valid = ((state_q == RUN) || (state_q == FLUSH)) && !flush_q && !stall;
`ifdef PC_MISALIGN_CHECK_EN
   assign misalign_fault = misalign_q;
`endif

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch PC.
module tb_pc_update;

   localparam int          AW       = 32;
   localparam logic [31:0] RST_PC   = 32'h0000_0100;
   localparam int          FLUSH_N  = 2;

   logic          clock;
   logic          reset_n;
   logic [1:0]    pc_src;
   logic [31:0]   branch_target;
   logic [31:0]   jump_target;
   logic          stall;
   logic [31:0]   pc;
   logic [31:0]   pc_next_seq;
   logic          fetch_valid;
   logic          flush;
   logic          redirect;
`ifdef PC_MISALIGN_CHECK_EN
   logic          misalign_fault;
`endif

   pc_update #(
      .ADDR_WIDTH   (AW),
      .RESET_PC     (RST_PC),
      .INSTR_BYTES  (4),
      .FLUSH_CYCLES (FLUSH_N)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .stall         (stall),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .fetch_valid   (fetch_valid),
      .flush         (flush),
      .redirect      (redirect)
`ifdef PC_MISALIGN_CHECK_EN
      ,
      .misalign_fault(misalign_fault)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural model: what fetch should look like, tracked as plain numbers.
   logic [31:0] mPc;
   bit          mStarted;
   int          mFlushLeft;
   bit          mRedirect;
   bit          mHalt;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%08h required 0x%08h at %0t", tag, observed, expected, $time);
   endtask

   task automatic modelReset();
      mPc        = RST_PC;
      mStarted   = 0;
      mFlushLeft = 0;
      mRedirect  = 0;
      mHalt      = 0;
   endtask

   task automatic modelStep(input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt, input logic st);
      logic [31:0] tgt;
      tgt = (src == 2'b10) ? jt : bt;
      mRedirect = 0;
      if (mHalt) return;
      if (!mStarted) begin
         mStarted = 1;
         return;
      end
      if (src == 2'b01 || src == 2'b10) begin
`ifdef PC_MISALIGN_CHECK_EN
         if (tgt % 4 != 0) begin
            mHalt = 1;
            return;
         end
`endif
         mPc        = tgt;
         mRedirect  = 1;
         mFlushLeft = FLUSH_N;
      end else begin
         if (!st) mPc = mPc + 32'd4;
         if (mFlushLeft > 0) mFlushLeft--;
      end
   endtask

   task automatic checkAll(input string tag);
      bit expFlush;
      expFlush = mHalt || (mFlushLeft > 0);
      checkOutput({tag, ".pc"}, pc, mPc);
      checkOutput({tag, ".pc_next_seq"}, pc_next_seq, mPc + 32'd4);
      checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, expFlush});
      checkOutput({tag, ".redirect"}, {31'd0, redirect}, {31'd0, mRedirect});
      checkOutput({tag, ".fetch_valid"}, {31'd0, fetch_valid},
                  {31'd0, (mStarted && !mHalt && !expFlush && !stall)});
`ifdef PC_MISALIGN_CHECK_EN
      checkOutput({tag, ".misalign_fault"}, {31'd0, misalign_fault}, {31'd0, mHalt});
`endif
   endtask

   // Called at a falling edge: drive inputs, check the present state, then clock once.
   task automatic applyStimulus(input string tag, input logic [1:0] src, input logic [31:0] bt,
                                input logic [31:0] jt, input logic st);
      pc_src        = src;
      branch_target = bt;
      jump_target   = jt;
      stall         = st;
      #1;
      checkAll(tag);
      @(posedge clock);
      modelStep(src, bt, jt, st);
      @(negedge clock);
   endtask

   initial begin
      logic [31:0] rbt, rjt;
      logic [1:0]  rsrc;
      logic        rst;
      int          pick;

      reset_n       = 1'b0;
      pc_src        = 2'b00;
      branch_target = '0;
      jump_target   = '0;
      stall         = 1'b0;
      modelReset();
      repeat (2) @(negedge clock);
      checkAll("reset");
      reset_n = 1'b1;

      // Release: pc holds for the IDLE->RUN edge, then advances
      applyStimulus("rel0", 2'b00, '0, '0, 1'b0);
      applyStimulus("rel1", 2'b00, '0, '0, 1'b0);
      applyStimulus("rel2", 2'b00, '0, '0, 1'b0);
      checkOutput("rel_pc108", pc, 32'h108);

      applyStimulus("jmp0", 2'b10, '0, 32'h400, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus("jmp", 2'b00, '0, '0, 1'b0);

      applyStimulus("brst", 2'b01, 32'h200, '0, 1'b1);
      checkOutput("brst_pc200", pc, 32'h200);
      for (int i = 0; i < 3; i++) applyStimulus("brst_hold", 2'b00, '0, '0, 1'b1);
      applyStimulus("brst_go", 2'b00, '0, '0, 1'b0);

      applyStimulus("b2b_j", 2'b10, '0, 32'h400, 1'b0);
      applyStimulus("b2b_b", 2'b01, 32'h800, '0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus("b2b", 2'b00, '0, '0, 1'b0);

      applyStimulus("wrap_j", 2'b10, '0, 32'hFFFF_FFF4, 1'b0);
      applyStimulus("wrap_a", 2'b00, '0, '0, 1'b0);
      applyStimulus("wrap_b", 2'b00, '0, '0, 1'b0);
      checkOutput("wrap_pcFC", pc, 32'hFFFF_FFFC);
      applyStimulus("wrap_rsv", 2'b11, 32'h1234, 32'h5678, 1'b0);
      checkOutput("wrap_pc0", pc, 32'h0);
      applyStimulus("wrap_end", 2'b00, '0, '0, 1'b0);

      // Reset lands between edges while the flush window is open
      applyStimulus("arst_j", 2'b10, '0, 32'h40, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_pc", pc, RST_PC);
      checkOutput("arst_flush", {31'd0, flush}, 32'd0);
      checkOutput("arst_redirect", {31'd0, redirect}, 32'd0);
      modelReset();
      @(negedge clock);
      reset_n = 1'b1;

      for (int n = 0; n < 400; n++) begin
         pick = $urandom_range(0, 9);
         rsrc = (pick < 6) ? 2'b00 : (pick == 6) ? 2'b01 : (pick == 7) ? 2'b10 : 2'b11;
         rbt  = $urandom;
         rjt  = $urandom;
`ifdef PC_MISALIGN_CHECK_EN
         rbt[1:0] = 2'b00;
         rjt[1:0] = 2'b00;
`endif
         rst  = ($urandom_range(0, 9) < 3);
         applyStimulus("rand", rsrc, rbt, rjt, rst);
      end

`ifdef PC_MISALIGN_CHECK_EN
      applyStimulus("mis_j", 2'b10, '0, 32'h400, 1'b0);
      applyStimulus("mis_a", 2'b00, '0, '0, 1'b0);
      applyStimulus("mis_b", 2'b00, '0, '0, 1'b0);
      applyStimulus("mis_bad", 2'b10, '0, 32'h402, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus("mis_halt", 2'b00, '0, '0, 1'b0);
      checkOutput("mis_fault", {31'd0, misalign_fault}, 32'd1);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
